// File: rtl/rv32_pkg.sv
// Shared RV32I definitions: base opcodes, immediate formats and the
// control bundle carried down the pipeline.
package rv32_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_t;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic branch;
        logic jump;
        logic illegal;
    } ctrl_t;

endpackage

// File: rtl/id_ex_stage_imm_gen.sv
// Combinational RV32I immediate generator; every format is sign-extended
// from instr[31]. Also used by the IF-stage branch predictor.
module imm_gen
    import rv32_pkg::*;
(
    input  logic [31:0] instr,
    input  imm_fmt_t    fmt,
    output logic [31:0] imm
);

    always_comb begin
        imm = {{20{instr[31]}}, instr[31:20]};
        case (fmt)
            IMM_I: imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B: imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U: imm = {instr[31:12], 12'b0};
            IMM_J: imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: ;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// RV32I decode stage and ID/EX pipeline register: immediate generation,
// operand forwarding/selection and load-use hazard detection.
module id_ex_stage
    import rv32_pkg::*;
#(
    parameter int          XLEN      = 32,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_valid,
    input  logic [31:0]     if_instr,
    input  logic [31:0]     if_pc,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      ex_mem_rd,
    input  logic            ex_mem_wr,
    input  logic [XLEN-1:0] ex_mem_data,
    input  logic [4:0]      mem_wb_rd,
    input  logic            mem_wb_wr,
    input  logic [XLEN-1:0] mem_wb_data,
    input  logic            stall_in,
    input  logic            flush,
    output logic            stall_req,
    output logic            ex_valid,
    output logic [6:0]      ex_opcode,
    output logic [2:0]      ex_funct3,
    output logic [6:0]      ex_funct7,
    output logic [XLEN-1:0] ex_in_one,
    output logic [XLEN-1:0] ex_in_two,
    output logic [XLEN-1:0] ex_store_data,
    output logic [31:0]     ex_pc,
    output logic [4:0]      ex_rd,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_branch,
    output logic            ex_jump,
    output logic            ex_illegal
);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [4:0]      rs1, rs2, rd;
    imm_fmt_t        imm_fmt;
    logic [31:0]     imm;
    logic [XLEN-1:0] fwd_rs1, fwd_rs2;

    logic [6:0]      d_opcode, d_funct7;
    logic [2:0]      d_funct3;
    logic [XLEN-1:0] d_in_one, d_in_two;
    logic            writes_rd, uses_rs1, uses_rs2;
    ctrl_t           d_ctrl, ex_ctrl;

    assign opcode = if_instr[6:0];
    assign funct3 = if_instr[14:12];
    assign rd     = if_instr[11:7];
    assign rs1    = if_instr[19:15];
    assign rs2    = if_instr[24:20];

    always_comb begin
        case (opcode)
            OP_STORE:         imm_fmt = IMM_S;
            OP_BRANCH:        imm_fmt = IMM_B;
            OP_LUI, OP_AUIPC: imm_fmt = IMM_U;
            OP_JAL:           imm_fmt = IMM_J;
            default:          imm_fmt = IMM_I;
        endcase
    end

    imm_gen u_imm_gen (
        .instr (if_instr),
        .fmt   (imm_fmt),
        .imm   (imm)
    );

    // x0 is never forwarded; the younger EX/MEM result beats MEM/WB.
    assign fwd_rs1 = (rs1 != 5'd0 && ex_mem_wr && ex_mem_rd == rs1) ? ex_mem_data :
                     (rs1 != 5'd0 && mem_wb_wr && mem_wb_rd == rs1) ? mem_wb_data : rs1_data;
    assign fwd_rs2 = (rs2 != 5'd0 && ex_mem_wr && ex_mem_rd == rs2) ? ex_mem_data :
                     (rs2 != 5'd0 && mem_wb_wr && mem_wb_rd == rs2) ? mem_wb_data : rs2_data;

    always_comb begin
        d_opcode  = opcode;
        d_funct3  = funct3;
        d_funct7  = '0;
        d_in_one  = fwd_rs1;
        d_in_two  = imm;
        d_ctrl    = '0;
        writes_rd = 1'b0;
        uses_rs1  = 1'b0;
        uses_rs2  = 1'b0;
        case (opcode)
            OP_R: begin
                d_in_two  = fwd_rs2;
                d_funct7  = if_instr[31:25];
                writes_rd = 1'b1;
                uses_rs1  = 1'b1;
                uses_rs2  = 1'b1;
            end
            OP_IMM: begin
                if (funct3 == 3'b001 || funct3 == 3'b101)
                    d_funct7 = if_instr[31:25];
                writes_rd = 1'b1;
                uses_rs1  = 1'b1;
            end
            OP_LOAD: begin
                d_ctrl.mem_read = 1'b1;
                writes_rd = 1'b1;
                uses_rs1  = 1'b1;
            end
            OP_JALR: begin
                d_ctrl.jump = 1'b1;
                writes_rd = 1'b1;
                uses_rs1  = 1'b1;
            end
            OP_STORE: begin
                d_ctrl.mem_write = 1'b1;
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OP_BRANCH: begin
                d_in_two = fwd_rs2;
                d_ctrl.branch = 1'b1;
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OP_JAL: begin
                d_in_one    = if_pc;
                d_ctrl.jump = 1'b1;
                writes_rd   = 1'b1;
            end
            // LUI/AUIPC become an ADDI so the ALU needs no extra opcodes.
            OP_LUI, OP_AUIPC: begin
                d_opcode  = OP_IMM;
                d_funct3  = 3'b000;
                d_in_one  = (opcode == OP_AUIPC) ? if_pc : '0;
                writes_rd = 1'b1;
            end
            default: begin
                d_in_one       = '0;
                d_in_two       = '0;
                d_ctrl.illegal = 1'b1;
            end
        endcase
        d_ctrl.reg_write = writes_rd && (rd != 5'd0);
    end

    assign stall_req = !flush && ex_valid && ex_ctrl.mem_read && (ex_rd != 5'd0) && if_valid &&
                       ((uses_rs1 && rs1 == ex_rd) || (uses_rs2 && rs2 == ex_rd));

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid      <= 1'b0;
            ex_ctrl       <= '0;
            ex_opcode     <= '0;
            ex_funct3     <= '0;
            ex_funct7     <= '0;
            ex_in_one     <= '0;
            ex_in_two     <= '0;
            ex_store_data <= '0;
            ex_pc         <= '0;
            ex_rd         <= '0;
        end else if (flush || (!stall_in && stall_req)) begin
            // Killed entries and load-use bubbles both look like a NOP to EX.
            ex_valid      <= 1'b0;
            ex_ctrl       <= '0;
            ex_opcode     <= NOP_INSTR[6:0];
            ex_funct3     <= NOP_INSTR[14:12];
            ex_funct7     <= '0;
            ex_in_one     <= '0;
            ex_in_two     <= '0;
            ex_store_data <= '0;
            ex_pc         <= '0;
            ex_rd         <= '0;
        end else if (!stall_in) begin
            ex_valid      <= if_valid;
            ex_ctrl       <= d_ctrl;
            ex_opcode     <= d_opcode;
            ex_funct3     <= d_funct3;
            ex_funct7     <= d_funct7;
            ex_in_one     <= d_in_one;
            ex_in_two     <= d_in_two;
            ex_store_data <= fwd_rs2;
            ex_pc         <= if_pc;
            ex_rd         <= writes_rd ? rd : 5'd0;
        end
    end

    assign ex_reg_write = ex_ctrl.reg_write;
    assign ex_mem_read  = ex_ctrl.mem_read;
    assign ex_mem_write = ex_ctrl.mem_write;
    assign ex_branch    = ex_ctrl.branch;
    assign ex_jump      = ex_ctrl.jump;
    assign ex_illegal   = ex_ctrl.illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: decode, forwarding, load-use bubble,
// flush/stall priority, with hand-computed expectations.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset, if_valid, ex_mem_wr, mem_wb_wr, stall_in, flush;
    logic [31:0] if_instr, if_pc, rs1_data, rs2_data, ex_mem_data, mem_wb_data;
    logic [4:0]  ex_mem_rd, mem_wb_rd;
    logic        stall_req, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
    logic        ex_branch, ex_jump, ex_illegal;
    logic [6:0]  ex_opcode, ex_funct7;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_in_one, ex_in_two, ex_store_data, ex_pc;
    logic [4:0]  ex_rd;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .reset(reset), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr), .ex_mem_data(ex_mem_data),
        .mem_wb_rd(mem_wb_rd), .mem_wb_wr(mem_wb_wr), .mem_wb_data(mem_wb_data),
        .stall_in(stall_in), .flush(flush), .stall_req(stall_req),
        .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_funct3(ex_funct3), .ex_funct7(ex_funct7),
        .ex_in_one(ex_in_one), .ex_in_two(ex_in_two), .ex_store_data(ex_store_data),
        .ex_pc(ex_pc), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_illegal(ex_illegal)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; if_valid = 1'b1; if_instr = 32'h00500093; if_pc = 32'h40;
        rs1_data = 32'h11; rs2_data = 32'h22; stall_in = 1'b1; flush = 1'b1;
        ex_mem_rd = 5'd0; ex_mem_wr = 1'b0; ex_mem_data = 32'h0;
        mem_wb_rd = 5'd0; mem_wb_wr = 1'b0; mem_wb_data = 32'h0;
        tick(); tick();
        vectors++; if (ex_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", ex_valid); end
        vectors++; if (ex_opcode !== 7'd0) begin miscompares++; $display("FAIL reset_opcode got %b want 0", ex_opcode); end
        vectors++; if (ex_in_two !== 32'd0) begin miscompares++; $display("FAIL reset_in_two got %h want 0", ex_in_two); end
        vectors++; if ({ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump, ex_illegal} !== 6'd0) begin
            miscompares++; $display("FAIL reset_ctrl got %b want 000000", {ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump, ex_illegal}); end
        vectors++; if ({ex_rd, ex_pc} !== 37'd0) begin miscompares++; $display("FAIL reset_rd_pc got %h want 0", {ex_rd, ex_pc}); end
        vectors++; if (stall_req !== 1'b0) begin miscompares++; $display("FAIL reset_stall_req got %b want 0", stall_req); end
        reset = 1'b0; stall_in = 1'b0; flush = 1'b0;
    endtask

    task automatic test_addi();
        if_instr = 32'h00500093; rs1_data = 32'h0;
        tick();
        vectors++; if (ex_valid !== 1'b1) begin miscompares++; $display("FAIL addi_valid got %b want 1", ex_valid); end
        vectors++; if (ex_opcode !== 7'b0010011 || ex_funct3 !== 3'b000 || ex_funct7 !== 7'd0) begin
            miscompares++; $display("FAIL addi_fields got %b/%b/%b want 0010011/000/0000000", ex_opcode, ex_funct3, ex_funct7); end
        vectors++; if (ex_in_one !== 32'd0 || ex_in_two !== 32'd5) begin
            miscompares++; $display("FAIL addi_operands got %h/%h want 0/5", ex_in_one, ex_in_two); end
        vectors++; if (ex_rd !== 5'd1 || ex_reg_write !== 1'b1) begin
            miscompares++; $display("FAIL addi_rd got %0d/%b want 1/1", ex_rd, ex_reg_write); end
        vectors++; if (ex_pc !== 32'h40) begin miscompares++; $display("FAIL addi_pc got %h want 40", ex_pc); end
    endtask

    task automatic test_load_use();
        if_instr = 32'h0000A103; rs1_data = 32'h100; if_pc = 32'h44;
        #1;
        vectors++; if (stall_req !== 1'b0) begin miscompares++; $display("FAIL lw_no_stall got %b want 0", stall_req); end
        tick();
        vectors++; if (ex_mem_read !== 1'b1 || ex_rd !== 5'd2 || ex_in_one !== 32'h100 || ex_in_two !== 32'd0) begin
            miscompares++; $display("FAIL lw_decode got mr=%b rd=%0d one=%h two=%h want 1/2/100/0", ex_mem_read, ex_rd, ex_in_one, ex_in_two); end
        if_instr = 32'h002101B3; rs1_data = 32'hDEAD; rs2_data = 32'hDEAD; if_pc = 32'h48;
        #1;
        vectors++; if (stall_req !== 1'b1) begin miscompares++; $display("FAIL load_use_stall got %b want 1", stall_req); end
        tick();
        vectors++; if (ex_valid !== 1'b0 || ex_mem_read !== 1'b0 || ex_reg_write !== 1'b0) begin
            miscompares++; $display("FAIL bubble got v=%b mr=%b rw=%b want 0/0/0", ex_valid, ex_mem_read, ex_reg_write); end
        mem_wb_rd = 5'd2; mem_wb_wr = 1'b1; mem_wb_data = 32'h55;
        #1;
        vectors++; if (stall_req !== 1'b0) begin miscompares++; $display("FAIL stall_released got %b want 0", stall_req); end
        tick();
        vectors++; if (ex_valid !== 1'b1 || ex_opcode !== 7'b0110011 || ex_rd !== 5'd3 || ex_reg_write !== 1'b1) begin
            miscompares++; $display("FAIL add_issue got v=%b op=%b rd=%0d rw=%b want 1/0110011/3/1", ex_valid, ex_opcode, ex_rd, ex_reg_write); end
        vectors++; if (ex_in_one !== 32'h55 || ex_in_two !== 32'h55) begin
            miscompares++; $display("FAIL add_wb_fwd got %h/%h want 55/55", ex_in_one, ex_in_two); end
        mem_wb_wr = 1'b0;
    endtask

    task automatic test_forward_priority();
        if_instr = 32'h00028333; rs1_data = 32'h7777; rs2_data = 32'h0;
        ex_mem_rd = 5'd5; ex_mem_wr = 1'b1; ex_mem_data = 32'h1234;
        mem_wb_rd = 5'd5; mem_wb_wr = 1'b1; mem_wb_data = 32'h9999;
        tick();
        vectors++; if (ex_in_one !== 32'h1234 || ex_in_two !== 32'h0) begin
            miscompares++; $display("FAIL fwd_exmem_wins got %h/%h want 1234/0", ex_in_one, ex_in_two); end
        ex_mem_wr = 1'b0;
        tick();
        vectors++; if (ex_in_one !== 32'h9999) begin miscompares++; $display("FAIL fwd_memwb got %h want 9999", ex_in_one); end
        mem_wb_wr = 1'b0;
        tick();
        vectors++; if (ex_in_one !== 32'h7777) begin miscompares++; $display("FAIL fwd_regfile got %h want 7777", ex_in_one); end
        // A write to x0 must never be forwarded.
        if_instr = 32'h00000333; rs1_data = 32'h0; ex_mem_rd = 5'd0; ex_mem_wr = 1'b1;
        tick();
        vectors++; if (ex_in_one !== 32'h0) begin miscompares++; $display("FAIL fwd_x0 got %h want 0", ex_in_one); end
        ex_mem_wr = 1'b0;
    endtask

    task automatic test_decode_formats();
        if_instr = 32'hFE208EE3; rs1_data = 32'h10; rs2_data = 32'h20;
        tick();
        vectors++; if (ex_branch !== 1'b1 || ex_reg_write !== 1'b0 || ex_rd !== 5'd0 || ex_jump !== 1'b0) begin
            miscompares++; $display("FAIL beq_ctrl got br=%b rw=%b rd=%0d j=%b want 1/0/0/0", ex_branch, ex_reg_write, ex_rd, ex_jump); end
        vectors++; if (ex_in_one !== 32'h10 || ex_in_two !== 32'h20) begin
            miscompares++; $display("FAIL beq_operands got %h/%h want 10/20", ex_in_one, ex_in_two); end
        if_instr = 32'h4030D093; rs1_data = 32'h80;
        tick();
        vectors++; if (ex_funct7 !== 7'b0100000 || ex_funct3 !== 3'b101 || ex_in_two[4:0] !== 5'd3) begin
            miscompares++; $display("FAIL srai got f7=%b f3=%b sh=%0d want 0100000/101/3", ex_funct7, ex_funct3, ex_in_two[4:0]); end
        if_instr = 32'h0020A423; rs1_data = 32'h100; rs2_data = 32'hABCD;
        tick();
        vectors++; if (ex_in_two !== 32'd8 || ex_store_data !== 32'hABCD || ex_mem_write !== 1'b1 || ex_reg_write !== 1'b0 || ex_rd !== 5'd0) begin
            miscompares++; $display("FAIL sw got two=%h sd=%h mw=%b rw=%b rd=%0d want 8/abcd/1/0/0", ex_in_two, ex_store_data, ex_mem_write, ex_reg_write, ex_rd); end
        if_instr = 32'h123452B7; rs1_data = 32'hFFFF;
        tick();
        vectors++; if (ex_opcode !== 7'b0010011 || ex_funct3 !== 3'b000 || ex_in_one !== 32'd0 || ex_in_two !== 32'h12345000 || ex_rd !== 5'd5 || ex_reg_write !== 1'b1) begin
            miscompares++; $display("FAIL lui got op=%b f3=%b one=%h two=%h rd=%0d want 0010011/000/0/12345000/5", ex_opcode, ex_funct3, ex_in_one, ex_in_two, ex_rd); end
        if_instr = 32'h12345297; if_pc = 32'h1000;
        tick();
        vectors++; if (ex_opcode !== 7'b0010011 || ex_in_one !== 32'h1000 || ex_in_two !== 32'h12345000) begin
            miscompares++; $display("FAIL auipc got op=%b one=%h two=%h want 0010011/1000/12345000", ex_opcode, ex_in_one, ex_in_two); end
        if_instr = 32'h010000EF; if_pc = 32'h200;
        tick();
        vectors++; if (ex_in_one !== 32'h200 || ex_in_two !== 32'd16 || ex_jump !== 1'b1 || ex_reg_write !== 1'b1 || ex_rd !== 5'd1) begin
            miscompares++; $display("FAIL jal got one=%h two=%h j=%b rw=%b rd=%0d want 200/10/1/1/1", ex_in_one, ex_in_two, ex_jump, ex_reg_write, ex_rd); end
        if_instr = 32'hFFFFFFFF;
        tick();
        vectors++; if (ex_illegal !== 1'b1 || ex_valid !== 1'b1 || {ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump} !== 5'd0) begin
            miscompares++; $display("FAIL illegal got ill=%b v=%b ctrl=%b want 1/1/00000", ex_illegal, ex_valid, {ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump}); end
    endtask

    task automatic test_flush_stall();
        if_instr = 32'h00500093; rs1_data = 32'h0; if_pc = 32'h80;
        tick();
        stall_in = 1'b1; if_instr = 32'h123452B7; if_pc = 32'h84;
        tick(); tick();
        vectors++; if (ex_valid !== 1'b1 || ex_opcode !== 7'b0010011 || ex_in_one !== 32'd0 || ex_in_two !== 32'd5 ||
                       ex_rd !== 5'd1 || ex_reg_write !== 1'b1 || ex_pc !== 32'h80) begin
            miscompares++; $display("FAIL stall_hold got v=%b two=%h rd=%0d pc=%h want 1/5/1/80", ex_valid, ex_in_two, ex_rd, ex_pc); end
        flush = 1'b1;
        tick();
        vectors++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0) begin
            miscompares++; $display("FAIL flush_over_stall got v=%b rw=%b want 0/0", ex_valid, ex_reg_write); end
        flush = 1'b0; stall_in = 1'b0;
        if_instr = 32'h0000A103; rs1_data = 32'h100;
        tick();
        if_instr = 32'h002101B3;
        #1;
        vectors++; if (stall_req !== 1'b1) begin miscompares++; $display("FAIL hazard_again got %b want 1", stall_req); end
        flush = 1'b1;
        #1;
        vectors++; if (stall_req !== 1'b0) begin miscompares++; $display("FAIL flush_masks_stall got %b want 0", stall_req); end
        tick();
        vectors++; if (ex_valid !== 1'b0 || ex_mem_read !== 1'b0) begin
            miscompares++; $display("FAIL flush_kills_load got v=%b mr=%b want 0/0", ex_valid, ex_mem_read); end
        flush = 1'b0;
    endtask

    initial begin
        test_reset();
        test_addi();
        test_load_use();
        test_forward_priority();
        test_decode_formats();
        test_flush_stall();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
